// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Purpose:
//   Shares one 16-bit single-port framebuffer RAM between the CPU bus and the
//   VGA row-prefetch engine. Every accepted request becomes one registered
//   memory access (ADDR cycle) followed by one acknowledge cycle (DATA cycle).
//   The arbiter always returns to IDLE between accesses, so each access takes
//   exactly three cycles. VGA wins when both sides request.
//
// Optional feature:
//   FB_ARB_FAIRNESS_EN - when defined, a saturating 4-bit starvation counter
//   forces a CPU grant after STARVE_LIMIT consecutive VGA grants made while
//   the CPU was waiting. When undefined, VGA priority is strict.
//
// Parameters:
//   STARVE_LIMIT  VGA grants with CPU pending before the CPU is forced (1-15).
//
// Ports:
//   sys_clk       in   1   system clock
//   reset         in   1   synchronous active-high reset
//   fb_access     in   1   VGA read request, held until fb_ack
//   fb_address    in  16   VGA word address
//   fb_ack        out  1   VGA completion pulse
//   fb_data       out 16   VGA read data, zero outside fb_ack
//   cpu_access    in   1   CPU request, held until cpu_ack
//   cpu_wr_en     in   1   1 = write, 0 = read
//   cpu_bytesel   in   2   CPU write byte enables ([0] = low byte)
//   cpu_address   in  16   CPU word address
//   cpu_wdata     in  16   CPU write data
//   cpu_ack       out  1   CPU completion pulse
//   cpu_rdata     out 16   CPU read data, zero outside a read ack
//   mem_address   out 16   registered RAM address
//   mem_wr_en     out  1   registered RAM write strobe
//   mem_bytesel   out  2   registered RAM byte enables
//   mem_wdata     out 16   registered RAM write data
//   mem_rdata     in  16   RAM read data (one cycle after the address)
// -----------------------------------------------------------------------------
module fb_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        fb_access,
    input  logic [15:0] fb_address,
    output logic        fb_ack,
    output logic [15:0] fb_data,
    input  logic        cpu_access,
    input  logic        cpu_wr_en,
    input  logic [1:0]  cpu_bytesel,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic [15:0] mem_address,
    output logic        mem_wr_en,
    output logic [1:0]  mem_bytesel,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VGA_ADDR = 3'd1,
        ST_VGA_DATA = 3'd2,
        ST_CPU_ADDR = 3'd3,
        ST_CPU_DATA = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_grant_vga;
    logic        w_grant_cpu;
    logic        w_force_cpu;

    logic [15:0] r_mem_address;
    logic        r_mem_wr_en;
    logic [1:0]  r_mem_bytesel;
    logic [15:0] r_mem_wdata;
    logic        r_fb_ack;
    logic        r_cpu_ack;
    logic        r_cpu_is_wr;

    // Elaboration-time guard on the starvation limit range.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("fb_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef FB_ARB_FAIRNESS_EN
    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    assign w_force_cpu = (r_starve_cnt == LP_STARVE_LIMIT);

    // Starvation counter: counts VGA wins over a waiting CPU, saturates at 15.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_cpu) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_vga && cpu_access) begin
            if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else if ((r_state == ST_IDLE) && !cpu_access) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`else
    assign w_force_cpu = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode; arbitration happens only in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_grant_vga  = 1'b0;
        w_grant_cpu  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_access && (!fb_access || w_force_cpu)) begin
                    w_next_state = ST_CPU_ADDR;
                    w_grant_cpu  = 1'b1;
                end else if (fb_access) begin
                    w_next_state = ST_VGA_ADDR;
                    w_grant_vga  = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_VGA_ADDR: w_next_state = ST_VGA_DATA;
            ST_VGA_DATA: w_next_state = ST_IDLE;
            ST_CPU_ADDR: w_next_state = ST_CPU_DATA;
            ST_CPU_DATA: w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Memory-side registers and ack pulses. The write strobe is only ever
    // loaded on a grant, so clearing it on every other cycle limits it to
    // the single ADDR cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_mem_address <= 16'h0000;
            r_mem_wr_en   <= 1'b0;
            r_mem_bytesel <= 2'b00;
            r_mem_wdata   <= 16'h0000;
            r_fb_ack      <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_cpu_is_wr   <= 1'b0;
        end else begin
            r_fb_ack  <= (r_state == ST_VGA_ADDR);
            r_cpu_ack <= (r_state == ST_CPU_ADDR);
            if (w_grant_vga) begin
                r_mem_address <= fb_address;
                r_mem_wr_en   <= 1'b0;
                r_mem_bytesel <= 2'b11;
                r_mem_wdata   <= 16'h0000;
                r_cpu_is_wr   <= 1'b0;
            end else if (w_grant_cpu) begin
                r_mem_address <= cpu_address;
                r_mem_wr_en   <= cpu_wr_en;
                r_mem_bytesel <= cpu_bytesel;
                r_mem_wdata   <= cpu_wdata;
                r_cpu_is_wr   <= cpu_wr_en;
            end else begin
                r_mem_wr_en   <= 1'b0;
            end
        end
    end

    assign mem_address = r_mem_address;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_bytesel = r_mem_bytesel;
    assign mem_wdata   = r_mem_wdata;
    assign fb_ack      = r_fb_ack;
    assign cpu_ack     = r_cpu_ack;
    // RAM output is already registered; gating by the ack register keeps the
    // data buses at zero outside their completion cycle.
    assign fb_data     = r_fb_ack ? mem_rdata : 16'h0000;
    assign cpu_rdata   = (r_cpu_ack && !r_cpu_is_wr) ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//
// Directed self-checking bench for fb_arbiter with a registered-output RAM
// model. Unwritten RAM words read as addr ^ 16'h5A5A, except 0x0050 which
// reads 0xA5A5. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        fb_access;
    logic [15:0] fb_address;
    logic        fb_ack;
    logic [15:0] fb_data;
    logic        cpu_access;
    logic        cpu_wr_en;
    logic [1:0]  cpu_bytesel;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_address;
    logic        mem_wr_en;
    logic [1:0]  mem_bytesel;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_mem   [0:65535];
    bit          wr_valid [0:65535];

    fb_arbiter #(.STARVE_LIMIT(8)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .fb_access  (fb_access),
        .fb_address (fb_address),
        .fb_ack     (fb_ack),
        .fb_data    (fb_data),
        .cpu_access (cpu_access),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_bytesel(cpu_bytesel),
        .cpu_address(cpu_address),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_address(mem_address),
        .mem_wr_en  (mem_wr_en),
        .mem_bytesel(mem_bytesel),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        if (wr_valid[a]) return wr_mem[a];
        else if (a == 16'h0050) return 16'hA5A5;
        else return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        return {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
    endfunction

    // Registered-output single-port RAM model.
    always @(posedge sys_clk) begin
        if (mem_wr_en) begin
            wr_mem[mem_address]   <= merge(ram_word(mem_address), mem_wdata, mem_bytesel);
            wr_valid[mem_address] <= 1'b1;
        end
        mem_rdata <= ram_word(mem_address);
    end

    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; fb_access = 1'b0; fb_address = 16'h0000;
        cpu_access = 1'b0; cpu_wr_en = 1'b0; cpu_bytesel = 2'b00;
        cpu_address = 16'h0000; cpu_wdata = 16'h0000;
        repeat (3) tick();
        checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_address got %h want 0000", mem_address); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mem_wr_en got %b want 0", mem_wr_en); end
        checks++; if (mem_bytesel !== 2'b00) begin errors++; $display("FAIL reset_mem_bytesel got %b want 00", mem_bytesel); end
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got %h want 0000", mem_wdata); end
        checks++; if (fb_ack !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b want 00", fb_ack, cpu_ack); end
        checks++; if (fb_data !== 16'h0000 || cpu_rdata !== 16'h0000) begin errors++; $display("FAIL reset_data got %h %h want 0", fb_data, cpu_rdata); end
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (fb_ack !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL idle_acks got %b%b want 00", fb_ack, cpu_ack); end
    endtask

    task automatic test_vga_single;
        fb_access = 1'b1; fb_address = 16'h0050;
        tick();
        checks++; if (mem_address !== 16'h0050) begin errors++; $display("FAIL vga_mem_address got %h want 0050", mem_address); end
        checks++; if (mem_bytesel !== 2'b11 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL vga_mem_ctrl got be=%b we=%b want 11/0", mem_bytesel, mem_wr_en); end
        checks++; if (fb_ack !== 1'b0) begin errors++; $display("FAIL vga_early_ack got %b want 0", fb_ack); end
        tick();
        checks++; if (fb_ack !== 1'b1) begin errors++; $display("FAIL vga_ack got %b want 1", fb_ack); end
        checks++; if (fb_data !== 16'hA5A5) begin errors++; $display("FAIL vga_data got %h want a5a5", fb_data); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL vga_cpu_ack got %b want 0", cpu_ack); end
        fb_access = 1'b0;
        tick();
        checks++; if (fb_ack !== 1'b0 || fb_data !== 16'h0000) begin errors++; $display("FAIL vga_ack_single got %b %h want 0 0000", fb_ack, fb_data); end
        tick();
    endtask

    task automatic test_cpu_write_read;
        cpu_access = 1'b1; cpu_wr_en = 1'b1; cpu_bytesel = 2'b01;
        cpu_address = 16'h1234; cpu_wdata = 16'hBEEF;
        tick();
        checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_strobe got %b want 1", mem_wr_en); end
        checks++; if (mem_bytesel !== 2'b01) begin errors++; $display("FAIL wr_bytesel got %b want 01", mem_bytesel); end
        checks++; if (mem_address !== 16'h1234 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_addr_data got %h %h want 1234 beef", mem_address, mem_wdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b want 0", cpu_ack); end
        tick();
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_strobe_len got %b want 0", mem_wr_en); end
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h0000) begin errors++; $display("FAIL wr_ack got %b %h want 1 0000", cpu_ack, cpu_rdata); end
        cpu_access = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_single got %b want 0", cpu_ack); end
        tick();
        // Read back: only the low byte may have changed (0x486E -> 0x48EF).
        cpu_access = 1'b1; cpu_wr_en = 1'b0; cpu_bytesel = 2'b00;
        tick();
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rd_strobe got %b want 0", mem_wr_en); end
        tick();
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h48EF) begin errors++; $display("FAIL rd_data got %b %h want 1 48ef", cpu_ack, cpu_rdata); end
        cpu_access = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_simultaneous;
        int fb_cyc = -1;
        int cpu_cyc = -1;
        fb_access = 1'b1; fb_address = 16'h0050;
        cpu_access = 1'b1; cpu_wr_en = 1'b0; cpu_address = 16'h1234;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (fb_ack && cpu_ack) begin errors++; checks++; $display("FAIL both_acks cycle %0d got 11 want not both", cyc); end
            if (fb_ack) begin fb_cyc = cyc; fb_access = 1'b0; end
            if (cpu_ack) begin
                cpu_cyc = cyc; cpu_access = 1'b0;
                checks++; if (cpu_rdata !== 16'h48EF) begin errors++; $display("FAIL sim_cpu_data got %h want 48ef", cpu_rdata); end
            end
        end
        checks++; if (fb_cyc != 2) begin errors++; $display("FAIL sim_vga_cycle got %0d want 2", fb_cyc); end
        checks++; if (cpu_cyc != 5) begin errors++; $display("FAIL sim_cpu_cycle got %0d want 5", cpu_cyc); end
    endtask

    task automatic test_starvation;
        int vga_before = 0;
        int vga_after = 0;
        int cpu_acks = 0;
        int late_cyc = -1;
        bit cpu_seen = 1'b0;
        fb_access = 1'b1; fb_address = 16'h0050;
        cpu_access = 1'b1; cpu_wr_en = 1'b0; cpu_address = 16'h1234;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            tick();
            if (fb_ack && cpu_ack) begin errors++; checks++; $display("FAIL starve_both_acks cycle %0d", cyc); end
            if (fb_ack) begin
                if (cpu_seen) vga_after++; else vga_before++;
                fb_access = 1'b0;
            end else begin
                fb_access = 1'b1;
            end
            if (cpu_ack) begin
                cpu_seen = 1'b1; cpu_acks++; cpu_access = 1'b0;
                checks++; if (cpu_rdata !== 16'h48EF) begin errors++; $display("FAIL starve_cpu_data got %h want 48ef", cpu_rdata); end
            end
        end
        fb_access = 1'b0;
`ifdef FB_ARB_FAIRNESS_EN
        checks++; if (vga_before != 8) begin errors++; $display("FAIL starve_vga_before got %0d want 8", vga_before); end
        checks++; if (cpu_acks != 1) begin errors++; $display("FAIL starve_cpu_acks got %0d want 1", cpu_acks); end
        checks++; if (vga_after < 1) begin errors++; $display("FAIL starve_vga_resume got %0d want >=1", vga_after); end
`else
        checks++; if (cpu_acks != 0) begin errors++; $display("FAIL strict_cpu_acks got %0d want 0", cpu_acks); end
        checks++; if (vga_before != 27) begin errors++; $display("FAIL strict_vga_acks got %0d want 27", vga_before); end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cpu_ack && late_cyc < 0) begin
                late_cyc = cyc; cpu_access = 1'b0;
                checks++; if (cpu_rdata !== 16'h48EF) begin errors++; $display("FAIL strict_cpu_data got %h want 48ef", cpu_rdata); end
            end
        end
        checks++; if (late_cyc != 3) begin errors++; $display("FAIL strict_cpu_release got %0d want 3", late_cyc); end
`endif
        cpu_access = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_access;
        int ack_cyc = -1;
        cpu_access = 1'b1; cpu_wr_en = 1'b1; cpu_bytesel = 2'b11;
        cpu_address = 16'h2222; cpu_wdata = 16'h1111;
        tick();
        checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe got %b want 1", mem_wr_en); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_ack !== 1'b0 || fb_ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %b%b want 00", cpu_ack, fb_ack); end
        checks++; if (mem_address !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_bus got %h %h want 0 0", mem_address, mem_wdata); end
        checks++; if (mem_wr_en !== 1'b0 || mem_bytesel !== 2'b00) begin errors++; $display("FAIL rst_mem_ctrl got %b %b want 0 00", mem_wr_en, mem_bytesel); end
        checks++; if (cpu_rdata !== 16'h0000 || fb_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h %h want 0 0", cpu_rdata, fb_data); end
        reset = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            if (cyc == 1) begin
                checks++; if (mem_wr_en !== 1'b1 || mem_address !== 16'h2222) begin errors++; $display("FAIL rst_retry_addr got %b %h want 1 2222", mem_wr_en, mem_address); end
            end
            if (cpu_ack && ack_cyc < 0) begin ack_cyc = cyc; cpu_access = 1'b0; end
        end
        checks++; if (ack_cyc != 2) begin errors++; $display("FAIL rst_retry_ack got %0d want 2", ack_cyc); end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        int prev = -1;
        logic [15:0] exp_addr;
        fb_access = 1'b1; fb_address = 16'h0100;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            tick();
            if (fb_ack) begin
                exp_addr = 16'h0100 + 16'(k);
                checks++; if (fb_data !== (exp_addr ^ 16'h5A5A) || mem_address !== exp_addr) begin
                    errors++; $display("FAIL burst_word %0d got %h @%h want %h @%h", k, fb_data, mem_address, exp_addr ^ 16'h5A5A, exp_addr);
                end
                if (prev >= 0) begin
                    checks++; if (cyc - prev != 3) begin errors++; $display("FAIL burst_spacing %0d got %0d want 3", k, cyc - prev); end
                end
                prev = cyc;
                k++;
                fb_address = 16'h0100 + 16'(k);
                fb_access = 1'b0;
            end else begin
                fb_access = (k < 160);
            end
            if (k == 160) break;
        end
        fb_access = 1'b0;
        checks++; if (k != 160) begin errors++; $display("FAIL burst_count got %0d want 160", k); end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_vga_single();
        test_cpu_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
